// File: rtl/wishbone_master_adapter_cpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wishbone_master_adapter_cpu_if                                             |
// | Classic single-beat Wishbone bus between the CPU bridge and the NoC fabric.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface wishbone_master_adapter_cpu_if;
  logic [31:0] addr;   // wb_addr_o
  logic [31:0] wdata;  // wb_data_o
  logic [31:0] rdata;  // wb_data_i
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output addr, wdata, we, sel, stb, cyc,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, we, sel, stb, cyc,
    output rdata, ack
  );
endinterface
`default_nettype wire

// File: rtl/wishbone_master_adapter_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wishbone_master_adapter_cpu                                                |
// | Bridges the RV32I load/store port onto a single-beat Wishbone master cycle.|
// | Optional ACK timeout: define WB_MASTER_TIMEOUT_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wishbone_master_adapter_cpu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  wishbone_master_adapter_cpu_if.master wb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q,    we_d;
  logic [3:0]  sel_q,   sel_d;
  logic        stb_q,   stb_d;
  logic        busy_q,  busy_d;
  logic        ready_q, ready_d;
  logic        tmo_hit;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // ACK beats a coincident terminal count
        if (wb.ack) begin
          if (!we_q) begin
            rdata_d = wb.rdata;
          end
          ready_d = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Bus strobes are flops keyed off the next state, so they never glitch
    stb_d  = (state_d == ST_BUS);
    busy_d = (state_d == ST_BUS) || (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;

  assign tmo_hit = (tmo_q == TMO_LAST);

  // Held at zero outside BUS, so every BUS entry starts from a clear count
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ST_BUS) begin
      tmo_d = '0;
    end else if (!wb.ack) begin
      tmo_d = tmo_q + 16'd1;
    end
    err_d = (state_q == ST_BUS) && !wb.ack && tmo_hit;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign cpu_err_o = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign cpu_err_o = 1'b0;
`endif

  assign wb.addr     = addr_q;
  assign wb.wdata    = wdata_q;
  assign wb.we       = we_q;
  assign wb.sel      = sel_q;
  assign wb.stb      = stb_q;
  assign wb.cyc      = stb_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_ready_o = ready_q;
  assign cpu_busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master_adapter_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wishbone_master_adapter_cpu                                             |
// | Vector table plus hand sequences against wishbone_master_adapter_cpu.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wishbone_master_adapter_cpu;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        cpu_busy;

  wishbone_master_adapter_cpu_if wb_if();

  wishbone_master_adapter_cpu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_we_i    (cpu_we),
    .cpu_sel_i   (cpu_sel),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ready_o (cpu_ready),
    .cpu_err_o   (cpu_err),
    .cpu_busy_o  (cpu_busy),
    .wb          (wb_if)
  );

  always #5 clk = ~clk;

  // dly = number of BUS cycles before the ACK cycle; negative = never ACK
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  sel;
    int          dly;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rdata = 32'h0;
  logic [31:0] sb_q[$];
  vec_t        vecs[7];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic we,
                              input logic [3:0] sel, input int dly);
    vec_t v;
    v.addr = a; v.wdata = wd; v.rd = rd; v.we = we; v.sel = sel; v.dly = dly;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int          n;
    int          exp_n;
    logic        exp_err;
    logic [31:0] exp_rd;
    exp_err = (v.dly < 0);
    exp_n   = exp_err ? TMO : v.dly + 1;
    if (exp_err) model_rdata = 32'h0;
    else if (!v.we) model_rdata = v.rd;
    sb_q.push_back(model_rdata);
    cpu_req = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_we = v.we; cpu_sel = v.sel;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = ~v.we; cpu_sel = ~v.sel;
    n = 0;
    while (wb_if.stb === 1'b1 && n < 64) begin
      chk({tag, " addr"},  wb_if.addr, v.addr);
      chk({tag, " wdata"}, wb_if.wdata, v.wdata);
      chk({tag, " we"},    32'(wb_if.we), 32'(v.we));
      chk({tag, " sel"},   32'(wb_if.sel), 32'(v.sel));
      chk({tag, " cyc"},   32'(wb_if.cyc), 32'h1);
      wb_if.ack   = (n == v.dly);
      wb_if.rdata = (n == v.dly) ? v.rd : $urandom;
      @(negedge clk);
      n++;
    end
    wb_if.ack = 1'b0;
    chk({tag, " stb_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, " ready"}, 32'(cpu_ready), 32'h1);
    chk({tag, " err"},   32'(cpu_err), 32'(exp_err));
    chk({tag, " cyc_in_resp"}, 32'(wb_if.cyc), 32'h0);
    chk({tag, " busy_in_resp"}, 32'(cpu_busy), 32'h1);
    exp_rd = sb_q.pop_front();
    chk({tag, " rdata"}, cpu_rdata, exp_rd);
    @(negedge clk);
    chk({tag, " ready_pulse"}, 32'(cpu_ready), 32'h0);
    chk({tag, " busy_idle"}, 32'(cpu_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          started;
    int          readys;
    logic [9:0]  pat;
    logic [31:0] exp_rd;

    vecs[0] = mk(32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'hF, 1);
    vecs[1] = mk(32'h1000_0000, 32'h0000_00FF, 32'h1111_2222, 1'b1, 4'h1, 1);
    vecs[2] = mk(32'h2000_0010, 32'h0,         32'h1234_5678, 1'b0, 4'hF, 0);
    vecs[3] = mk(32'h3000_0008, 32'hCAFE_BABE, 32'h3333_4444, 1'b1, 4'hC, 5);
    vecs[4] = mk(32'h1000_0020, 32'h0,         32'hA5A5_5A5A, 1'b0, 4'h3, 5);
    vecs[5] = mk(32'h4000_0000, 32'h55AA_55AA, 32'h7777_8888, 1'b1, 4'hF, 0);
    vecs[6] = mk(32'h0000_0FFC, 32'h0,         32'h8000_0001, 1'b0, 4'h8, 2);

    rst_n = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_sel = '0;
    wb_if.ack = 1'b0; wb_if.rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst stb",   32'(wb_if.stb), 32'h0);
    chk("rst cyc",   32'(wb_if.cyc), 32'h0);
    chk("rst we",    32'(wb_if.we), 32'h0);
    chk("rst addr",  wb_if.addr, 32'h0);
    chk("rst wdata", wb_if.wdata, 32'h0);
    chk("rst sel",   32'(wb_if.sel), 32'h0);
    chk("rst rdata", cpu_rdata, 32'h0);
    chk("rst ready", 32'(cpu_ready), 32'h0);
    chk("rst err",   32'(cpu_err), 32'h0);
    chk("rst busy",  32'(cpu_busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Stray ACK while idle
    wb_if.ack = 1'b1; wb_if.rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray ready", 32'(cpu_ready), 32'h0);
      chk("stray cyc",   32'(wb_if.cyc), 32'h0);
      chk("stray busy",  32'(cpu_busy), 32'h0);
      chk("stray rdata", cpu_rdata, model_rdata);
    end
    wb_if.ack = 1'b0;
    @(negedge clk);

    // Request held high, zero-wait slave: BUS, RESP, IDLE repeating
    started = 0; readys = 0; pat = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000_0000; cpu_sel = 4'hF;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 10) pat[i] = wb_if.cyc;
      if (cpu_ready === 1'b1) begin
        readys++;
        exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        chk("b2b rdata", cpu_rdata, exp_rd);
      end
      if (wb_if.stb === 1'b1) begin
        started++;
        model_rdata = 32'h0BAD_F00D ^ 32'(started);
        sb_q.push_back(model_rdata);
        wb_if.ack = 1'b1; wb_if.rdata = model_rdata;
      end else begin
        wb_if.ack = 1'b0; wb_if.rdata = $urandom;
      end
      if (i == 9) cpu_req = 1'b0;
    end
    wb_if.ack = 1'b0;
    chk("b2b cyc_pattern", 32'(pat), 32'h249);
    chk("b2b started", 32'(started), 32'd4);
    chk("b2b readys",  32'(readys), 32'd4);
    sb_q.delete();

`ifdef WB_MASTER_TIMEOUT_EN
    run_txn(mk(32'h6000_0000, 32'h0, 32'h9999_9999, 1'b0, 4'hF, -1), "timeout");
`else
    run_txn(mk(32'h6000_0000, 32'h0, 32'h9999_9999, 1'b0, 4'hF, 20), "longwait");
`endif
    run_txn(mk(32'h6000_0004, 32'h0, 32'hBEEF_0008, 1'b0, 4'hF, TMO - 1), "ack_last");

    // Async reset in the second BUS cycle
    cpu_req = 1'b1; cpu_addr = 32'h7000_0000; cpu_we = 1'b0; cpu_sel = 4'hF;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("arst bus1 stb", 32'(wb_if.stb), 32'h1);
    @(negedge clk);
    chk("arst bus2 stb", 32'(wb_if.stb), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst stb",   32'(wb_if.stb), 32'h0);
    chk("arst cyc",   32'(wb_if.cyc), 32'h0);
    chk("arst busy",  32'(cpu_busy), 32'h0);
    chk("arst ready", 32'(cpu_ready), 32'h0);
    chk("arst err",   32'(cpu_err), 32'h0);
    chk("arst rdata", cpu_rdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst ready", 32'(cpu_ready), 32'h0);
    chk("post_rst stb",   32'(wb_if.stb), 32'h0);
    run_txn(vecs[0], "post_rst_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
